// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI device-side responder.
// Register select codes, the bus FSM states and the STATUS word layout.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } hpi_state_t;

    localparam int STATUS_MBX_OUT_BIT = 0;
    localparam int STATUS_MBX_IN_BIT  = 8;

    // Mailbox flags overlay the fixed STATUS bits.
    function automatic logic [15:0] status_word(input logic [15:0] base,
                                                input logic        out_full,
                                                input logic        in_full);
        logic [15:0] w;
        w = base;
        w[STATUS_MBX_OUT_BIT] = out_full;
        w[STATUS_MBX_IN_BIT]  = in_full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_dpram.sv
// Simple dual-port word RAM, registered read on both ports.
// Port A (host) wins when both ports write the same word in one cycle.
module hpi_dpram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_q,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Port A is written last so its value lands on an address collision.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= mem[a_addr];
            b_q <= mem[b_addr];
        end
    end

endmodule

// File: rtl/hpi_responder.sv
// Device side of the CY7C67200 Host Port Interface: word memory, auto-increment
// address register, two mailboxes and OTG_INT, plus a local firmware-model port.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter logic [15:0] INIT_STATUS = 16'h0000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        OTG_ADDR,
    input  logic              OTG_CS_N,
    input  logic              OTG_RD_N,
    input  logic              OTG_WR_N,
    input  logic              OTG_RST_N,
    input  logic [15:0]       OTG_DATA_IN,
    output logic [15:0]       OTG_DATA_OUT,
    output logic              OTG_DATA_OE,
    output logic              OTG_INT,
    input  logic [MEM_AW-1:0] loc_addr,
    input  logic              loc_we,
    input  logic [15:0]       loc_wdata,
    output logic [15:0]       loc_rdata,
    input  logic              loc_mbx_we,
    input  logic [15:0]       loc_mbx_wdata,
    input  logic              loc_mbx_ack,
    output logic [15:0]       loc_mbx_in,
    output logic              loc_mbx_in_valid,
    output logic              proto_err,
    output logic              mbx_ovf
);

    hpi_state_t  state;
    hpi_reg_t    sel_q;
    logic [15:0] addr_reg;
    logic [15:0] wdata_q;
    logic [15:0] mbx_out;
    logic        mbx_out_full;
    logic [15:0] mbx_in;
    logic        mbx_in_full;
    logic [15:0] data_out;
    logic        oe;
    logic [15:0] ram_q;
    logic [15:0] rd_value;

    logic strobe_rd;
    logic strobe_wr;
    logic strobe_both;
    logic rd_release;
    logic wr_release;
    logic soft_rst;
    logic commit;
    logic host_we;
    logic mbx_rd_done;

    assign strobe_rd   = !OTG_CS_N && !OTG_RD_N &&  OTG_WR_N;
    assign strobe_wr   = !OTG_CS_N &&  OTG_RD_N && !OTG_WR_N;
    assign strobe_both = !OTG_CS_N && !OTG_RD_N && !OTG_WR_N;
    assign rd_release  = OTG_CS_N || OTG_RD_N;
    assign wr_release  = OTG_CS_N || OTG_WR_N;
    assign soft_rst    = !OTG_RST_N;

    // Write side effects happen on the first cycle the strobe is seen released.
    assign commit      = (state == WRITE) && wr_release && !soft_rst;
    assign host_we     = commit && (sel_q == HPI_DATA);
    assign mbx_rd_done = (state == READ) && rd_release && !soft_rst && (sel_q == HPI_MAILBOX);

    hpi_dpram #(
        .AW (MEM_AW),
        .DW (16)
    ) u_ram (
        .clk     (Clk),
        .rst     (Reset),
        .a_addr  (addr_reg[MEM_AW:1]),
        .a_we    (host_we),
        .a_wdata (wdata_q),
        .a_q     (ram_q),
        .b_addr  (loc_addr),
        .b_we    (loc_we),
        .b_wdata (loc_wdata),
        .b_q     (loc_rdata)
    );

    always_comb begin
        rd_value = '0;
        case (sel_q)
            HPI_DATA:    rd_value = ram_q;
            HPI_MAILBOX: rd_value = mbx_out;
            HPI_ADDRESS: rd_value = addr_reg;
            HPI_STATUS:  rd_value = status_word(INIT_STATUS, mbx_out_full, mbx_in_full);
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            sel_q        <= HPI_DATA;
            addr_reg     <= '0;
            wdata_q      <= '0;
            mbx_out      <= '0;
            mbx_out_full <= 1'b0;
            mbx_in       <= '0;
            mbx_in_full  <= 1'b0;
            data_out     <= '0;
            oe           <= 1'b0;
            proto_err    <= 1'b0;
            mbx_ovf      <= 1'b0;
        end else begin
            if (strobe_both) begin
                proto_err <= 1'b1;
            end
            if (soft_rst) begin
                // Memory and the sticky error flags survive a soft reset.
                state        <= IDLE;
                addr_reg     <= '0;
                mbx_out      <= '0;
                mbx_out_full <= 1'b0;
                mbx_in       <= '0;
                mbx_in_full  <= 1'b0;
                data_out     <= '0;
                oe           <= 1'b0;
            end else begin
                // Local mailbox actions come first so same-cycle host events override them,
                // except the outgoing load, which must beat a host mailbox-read release.
                if (loc_mbx_ack) begin
                    mbx_in_full <= 1'b0;
                end
                if (mbx_rd_done) begin
                    mbx_out_full <= 1'b0;
                end
                if (loc_mbx_we) begin
                    mbx_out      <= loc_mbx_wdata;
                    mbx_out_full <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (strobe_rd) begin
                            state <= READ;
                            sel_q <= hpi_reg_t'(OTG_ADDR);
                        end else if (strobe_wr) begin
                            state   <= WRITE;
                            sel_q   <= hpi_reg_t'(OTG_ADDR);
                            wdata_q <= OTG_DATA_IN;
                        end
                    end
                    READ: begin
                        if (rd_release) begin
                            oe    <= 1'b0;
                            state <= IDLE;
                            if (sel_q == HPI_DATA) begin
                                addr_reg <= addr_reg + 16'd2;
                            end
                        end else if (!oe) begin
                            data_out <= rd_value;
                            oe       <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (wr_release) begin
                            state <= IDLE;
                            case (sel_q)
                                HPI_DATA:    addr_reg <= addr_reg + 16'd2;
                                HPI_ADDRESS: addr_reg <= wdata_q;
                                HPI_MAILBOX: begin
                                    mbx_in      <= wdata_q;
                                    mbx_in_full <= 1'b1;
                                    if (mbx_in_full) begin
                                        mbx_ovf <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            wdata_q <= OTG_DATA_IN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign OTG_DATA_OUT     = data_out;
    assign OTG_DATA_OE      = oe;
    assign OTG_INT          = mbx_out_full;
    assign loc_mbx_in       = mbx_in;
    assign loc_mbx_in_valid = mbx_in_full;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: host reads are scored against an expected
// queue by a monitor; flags and local-port values are compared in line.
module tb_hpi_responder;
    import hpi_pkg::*;

    localparam int MEM_AW = 10;

    logic              clk;
    logic              rst;
    logic [1:0]        otg_addr;
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              rst_n;
    logic [15:0]       data_in;
    logic [15:0]       data_out;
    logic              data_oe;
    logic              otg_int;
    logic [MEM_AW-1:0] loc_addr;
    logic              loc_we;
    logic [15:0]       loc_wdata;
    logic [15:0]       loc_rdata;
    logic              loc_mbx_we;
    logic [15:0]       loc_mbx_wdata;
    logic              loc_mbx_ack;
    logic [15:0]       loc_mbx_in;
    logic              loc_mbx_in_valid;
    logic              proto_err;
    logic              mbx_ovf;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic        oe_prev = 1'b0;

    hpi_responder #(
        .MEM_AW      (MEM_AW),
        .INIT_STATUS (16'h0000)
    ) dut (
        .Clk              (clk),
        .Reset            (rst),
        .OTG_ADDR         (otg_addr),
        .OTG_CS_N         (cs_n),
        .OTG_RD_N         (rd_n),
        .OTG_WR_N         (wr_n),
        .OTG_RST_N        (rst_n),
        .OTG_DATA_IN      (data_in),
        .OTG_DATA_OUT     (data_out),
        .OTG_DATA_OE      (data_oe),
        .OTG_INT          (otg_int),
        .loc_addr         (loc_addr),
        .loc_we           (loc_we),
        .loc_wdata        (loc_wdata),
        .loc_rdata        (loc_rdata),
        .loc_mbx_we       (loc_mbx_we),
        .loc_mbx_wdata    (loc_mbx_wdata),
        .loc_mbx_ack      (loc_mbx_ack),
        .loc_mbx_in       (loc_mbx_in),
        .loc_mbx_in_valid (loc_mbx_in_valid),
        .proto_err        (proto_err),
        .mbx_ovf          (mbx_ovf)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising OE presents one read word.
    always @(negedge clk) begin
        if (data_oe && !oe_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got %h, expected none", data_out);
            end else begin
                logic [15:0] exp;
                exp = exp_q.pop_front();
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL read_data: got %h, expected %h", data_out, exp);
                end
            end
        end
        oe_prev = data_oe;
    end

    // Driver tasks
    task automatic host_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        otg_addr = sel;
        data_in  = ~data;
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        @(negedge clk);
        data_in  = data;
        @(negedge clk);
        cs_n     = 1'b1;
        wr_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_read(input logic [1:0] sel, input logic [15:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        otg_addr = sel;
        cs_n     = 1'b0;
        rd_n     = 1'b0;
        @(negedge clk);
        check("oe_before", data_oe, 1'b0);
        @(negedge clk);
        check("oe_latency", data_oe, 1'b1);
        cs_n = 1'b1;
        rd_n = 1'b1;
        @(negedge clk);
        check("oe_release", data_oe, 1'b0);
    endtask

    task automatic local_write(input logic [MEM_AW-1:0] addr, input logic [15:0] data);
        @(negedge clk);
        loc_addr  = addr;
        loc_wdata = data;
        loc_we    = 1'b1;
        @(negedge clk);
        loc_we    = 1'b0;
    endtask

    task automatic local_read(input string name, input logic [MEM_AW-1:0] addr, input logic [15:0] exp);
        @(negedge clk);
        loc_addr = addr;
        @(negedge clk);
        check(name, loc_rdata, exp);
    endtask

    task automatic local_mbx_load(input logic [15:0] data);
        @(negedge clk);
        loc_mbx_wdata = data;
        loc_mbx_we    = 1'b1;
        @(negedge clk);
        loc_mbx_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; otg_addr = 2'd0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rst_n = 1'b1;
        data_in = '0; loc_addr = '0; loc_we = 1'b0; loc_wdata = '0;
        loc_mbx_we = 1'b0; loc_mbx_wdata = '0; loc_mbx_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_oe", data_oe, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_int", otg_int, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_mbx_ovf", mbx_ovf, 1'b0);
        check("rst_mbx_valid", loc_mbx_in_valid, 1'b0);
        check("rst_loc_rdata", loc_rdata, 16'h0000);

        // Auto-incrementing DATA writes
        host_write(HPI_ADDRESS, 16'h0100);
        host_write(HPI_DATA, 16'hAAAA);
        host_write(HPI_DATA, 16'h5555);
        host_read(HPI_ADDRESS, 16'h0104);
        local_read("mem128", 10'd128, 16'hAAAA);
        local_read("mem129", 10'd129, 16'h5555);

        // Local write, host DATA read
        local_write(10'd7, 16'h1234);
        host_write(HPI_ADDRESS, 16'h000E);
        host_read(HPI_DATA, 16'h1234);
        host_read(HPI_ADDRESS, 16'h0010);

        // Outgoing mailbox and interrupt
        host_read(HPI_STATUS, 16'h0000);
        local_mbx_load(16'hBEEF);
        check("int_set", otg_int, 1'b1);
        host_read(HPI_STATUS, 16'h0001);
        host_read(HPI_MAILBOX, 16'hBEEF);
        check("int_clear", otg_int, 1'b0);
        host_read(HPI_STATUS, 16'h0000);

        // Incoming mailbox and overflow
        host_write(HPI_MAILBOX, 16'h0001);
        check("mbx_in_valid", loc_mbx_in_valid, 1'b1);
        check("mbx_in_first", loc_mbx_in, 16'h0001);
        check("mbx_ovf_clear", mbx_ovf, 1'b0);
        host_write(HPI_MAILBOX, 16'h0002);
        check("mbx_in_second", loc_mbx_in, 16'h0002);
        check("mbx_ovf_set", mbx_ovf, 1'b1);
        host_read(HPI_STATUS, 16'h0100);
        @(negedge clk);
        loc_mbx_ack = 1'b1;
        @(negedge clk);
        loc_mbx_ack = 1'b0;
        check("mbx_ack_valid", loc_mbx_in_valid, 1'b0);
        check("mbx_ovf_sticky", mbx_ovf, 1'b1);

        // Both strobes low: protocol error, no side effects
        local_write(10'd8, 16'h0808);
        @(negedge clk);
        otg_addr = HPI_DATA; data_in = 16'hFFFF; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("proto_oe", data_oe, 1'b0);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("proto_err", proto_err, 1'b1);
        check("proto_oe_after", data_oe, 1'b0);
        host_read(HPI_ADDRESS, 16'h0010);
        local_read("proto_mem8", 10'd8, 16'h0808);

        // Soft reset aborts a DATA write in flight
        local_mbx_load(16'h7777);
        check("int_before_srst", otg_int, 1'b1);
        host_write(HPI_MAILBOX, 16'h3333);
        check("valid_before_srst", loc_mbx_in_valid, 1'b1);
        host_write(HPI_ADDRESS, 16'h0020);
        local_write(10'd16, 16'h1616);
        @(negedge clk);
        otg_addr = HPI_DATA; data_in = 16'hDEAD; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("srst_int", otg_int, 1'b0);
        check("srst_valid", loc_mbx_in_valid, 1'b0);
        check("srst_mbx_in", loc_mbx_in, 16'h0000);
        check("srst_proto_err", proto_err, 1'b1);
        check("srst_mbx_ovf", mbx_ovf, 1'b1);
        local_read("srst_mem16", 10'd16, 16'h1616);
        host_read(HPI_ADDRESS, 16'h0000);

        // Same-word collision: host commit beats local write
        host_write(HPI_ADDRESS, 16'h0040);
        @(negedge clk);
        otg_addr = HPI_DATA; data_in = 16'h1111; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        loc_addr = 10'd32; loc_wdata = 16'h2222; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        local_read("collide_mem32", 10'd32, 16'h1111);
        host_read(HPI_ADDRESS, 16'h0042);

        // Address wrap at the top of both spaces
        host_write(HPI_ADDRESS, 16'hFFFE);
        host_write(HPI_DATA, 16'hC0DE);
        local_read("wrap_mem1023", 10'd1023, 16'hC0DE);
        host_read(HPI_ADDRESS, 16'h0000);

        // Async reset while a read is driving the bus
        local_mbx_load(16'h5A5A);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        otg_addr = HPI_ADDRESS; cs_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ar_oe_on", data_oe, 1'b1);
        #2 rst = 1'b1;
        #1 check("ar_oe_off", data_oe, 1'b0);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_int", otg_int, 1'b0);
        check("ar_proto_err", proto_err, 1'b0);
        check("ar_mbx_ovf", mbx_ovf, 1'b0);
        check("ar_data_out", data_out, 16'h0000);

        repeat (2) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
